// File: rtl/riscv_enc_pkg.sv
// Shared types and constants for the RV32IM instruction encoder.
// The MATCH_* words are the fixed opcode/funct3/funct7 bits of each instruction.
package riscv_enc_pkg;

    typedef enum logic [5:0] {
        OP_ADD    = 6'd0,  OP_SUB    = 6'd1,  OP_SLL   = 6'd2,  OP_SLT   = 6'd3,
        OP_SLTU   = 6'd4,  OP_XOR    = 6'd5,  OP_SRL   = 6'd6,  OP_SRA   = 6'd7,
        OP_OR     = 6'd8,  OP_AND    = 6'd9,  OP_MUL   = 6'd10, OP_MULH  = 6'd11,
        OP_MULHSU = 6'd12, OP_MULHU  = 6'd13, OP_DIV   = 6'd14, OP_DIVU  = 6'd15,
        OP_REM    = 6'd16, OP_REMU   = 6'd17,
        OP_ADDI   = 6'd18, OP_SLTI   = 6'd19, OP_SLTIU = 6'd20, OP_XORI  = 6'd21,
        OP_ORI    = 6'd22, OP_ANDI   = 6'd23, OP_LB    = 6'd24, OP_LH    = 6'd25,
        OP_LW     = 6'd26, OP_LBU    = 6'd27, OP_LHU   = 6'd28, OP_JALR  = 6'd29,
        OP_SLLI   = 6'd30, OP_SRLI   = 6'd31, OP_SRAI  = 6'd32,
        OP_SB     = 6'd33, OP_SH     = 6'd34, OP_SW    = 6'd35,
        OP_BEQ    = 6'd36, OP_BNE    = 6'd37, OP_BLT   = 6'd38, OP_BGE   = 6'd39,
        OP_BLTU   = 6'd40, OP_BGEU   = 6'd41,
        OP_LUI    = 6'd42, OP_AUIPC  = 6'd43,
        OP_JAL    = 6'd44
    } op_e;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_SH  = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6,
        FMT_BAD = 3'd7
    } fmt_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [31:0] MATCH_ADD    = 32'h0000_0033, MATCH_SUB    = 32'h4000_0033;
    localparam logic [31:0] MATCH_SLL    = 32'h0000_1033, MATCH_SLT    = 32'h0000_2033;
    localparam logic [31:0] MATCH_SLTU   = 32'h0000_3033, MATCH_XOR    = 32'h0000_4033;
    localparam logic [31:0] MATCH_SRL    = 32'h0000_5033, MATCH_SRA    = 32'h4000_5033;
    localparam logic [31:0] MATCH_OR     = 32'h0000_6033, MATCH_AND    = 32'h0000_7033;
    localparam logic [31:0] MATCH_MUL    = 32'h0200_0033, MATCH_MULH   = 32'h0200_1033;
    localparam logic [31:0] MATCH_MULHSU = 32'h0200_2033, MATCH_MULHU  = 32'h0200_3033;
    localparam logic [31:0] MATCH_DIV    = 32'h0200_4033, MATCH_DIVU   = 32'h0200_5033;
    localparam logic [31:0] MATCH_REM    = 32'h0200_6033, MATCH_REMU   = 32'h0200_7033;
    localparam logic [31:0] MATCH_ADDI   = 32'h0000_0013, MATCH_SLTI   = 32'h0000_2013;
    localparam logic [31:0] MATCH_SLTIU  = 32'h0000_3013, MATCH_XORI   = 32'h0000_4013;
    localparam logic [31:0] MATCH_ORI    = 32'h0000_6013, MATCH_ANDI   = 32'h0000_7013;
    localparam logic [31:0] MATCH_LB     = 32'h0000_0003, MATCH_LH     = 32'h0000_1003;
    localparam logic [31:0] MATCH_LW     = 32'h0000_2003, MATCH_LBU    = 32'h0000_4003;
    localparam logic [31:0] MATCH_LHU    = 32'h0000_5003, MATCH_JALR   = 32'h0000_0067;
    localparam logic [31:0] MATCH_SLLI   = 32'h0000_1013, MATCH_SRLI   = 32'h0000_5013;
    localparam logic [31:0] MATCH_SRAI   = 32'h4000_5013;
    localparam logic [31:0] MATCH_SB     = 32'h0000_0023, MATCH_SH     = 32'h0000_1023;
    localparam logic [31:0] MATCH_SW     = 32'h0000_2023;
    localparam logic [31:0] MATCH_BEQ    = 32'h0000_0063, MATCH_BNE    = 32'h0000_1063;
    localparam logic [31:0] MATCH_BLT    = 32'h0000_4063, MATCH_BGE    = 32'h0000_5063;
    localparam logic [31:0] MATCH_BLTU   = 32'h0000_6063, MATCH_BGEU   = 32'h0000_7063;
    localparam logic [31:0] MATCH_LUI    = 32'h0000_0037, MATCH_AUIPC  = 32'h0000_0017;
    localparam logic [31:0] MATCH_JAL    = 32'h0000_006F;

    typedef struct packed {
        fmt_e        fmt;
        logic [31:0] match;
    } op_info_t;

    function automatic op_info_t op_info(input logic [5:0] op);
        op_info_t info;
        case (op)
            OP_ADD:    info = op_info_t'{FMT_R,  MATCH_ADD};
            OP_SUB:    info = op_info_t'{FMT_R,  MATCH_SUB};
            OP_SLL:    info = op_info_t'{FMT_R,  MATCH_SLL};
            OP_SLT:    info = op_info_t'{FMT_R,  MATCH_SLT};
            OP_SLTU:   info = op_info_t'{FMT_R,  MATCH_SLTU};
            OP_XOR:    info = op_info_t'{FMT_R,  MATCH_XOR};
            OP_SRL:    info = op_info_t'{FMT_R,  MATCH_SRL};
            OP_SRA:    info = op_info_t'{FMT_R,  MATCH_SRA};
            OP_OR:     info = op_info_t'{FMT_R,  MATCH_OR};
            OP_AND:    info = op_info_t'{FMT_R,  MATCH_AND};
            OP_MUL:    info = op_info_t'{FMT_R,  MATCH_MUL};
            OP_MULH:   info = op_info_t'{FMT_R,  MATCH_MULH};
            OP_MULHSU: info = op_info_t'{FMT_R,  MATCH_MULHSU};
            OP_MULHU:  info = op_info_t'{FMT_R,  MATCH_MULHU};
            OP_DIV:    info = op_info_t'{FMT_R,  MATCH_DIV};
            OP_DIVU:   info = op_info_t'{FMT_R,  MATCH_DIVU};
            OP_REM:    info = op_info_t'{FMT_R,  MATCH_REM};
            OP_REMU:   info = op_info_t'{FMT_R,  MATCH_REMU};
            OP_ADDI:   info = op_info_t'{FMT_I,  MATCH_ADDI};
            OP_SLTI:   info = op_info_t'{FMT_I,  MATCH_SLTI};
            OP_SLTIU:  info = op_info_t'{FMT_I,  MATCH_SLTIU};
            OP_XORI:   info = op_info_t'{FMT_I,  MATCH_XORI};
            OP_ORI:    info = op_info_t'{FMT_I,  MATCH_ORI};
            OP_ANDI:   info = op_info_t'{FMT_I,  MATCH_ANDI};
            OP_LB:     info = op_info_t'{FMT_I,  MATCH_LB};
            OP_LH:     info = op_info_t'{FMT_I,  MATCH_LH};
            OP_LW:     info = op_info_t'{FMT_I,  MATCH_LW};
            OP_LBU:    info = op_info_t'{FMT_I,  MATCH_LBU};
            OP_LHU:    info = op_info_t'{FMT_I,  MATCH_LHU};
            OP_JALR:   info = op_info_t'{FMT_I,  MATCH_JALR};
            OP_SLLI:   info = op_info_t'{FMT_SH, MATCH_SLLI};
            OP_SRLI:   info = op_info_t'{FMT_SH, MATCH_SRLI};
            OP_SRAI:   info = op_info_t'{FMT_SH, MATCH_SRAI};
            OP_SB:     info = op_info_t'{FMT_S,  MATCH_SB};
            OP_SH:     info = op_info_t'{FMT_S,  MATCH_SH};
            OP_SW:     info = op_info_t'{FMT_S,  MATCH_SW};
            OP_BEQ:    info = op_info_t'{FMT_B,  MATCH_BEQ};
            OP_BNE:    info = op_info_t'{FMT_B,  MATCH_BNE};
            OP_BLT:    info = op_info_t'{FMT_B,  MATCH_BLT};
            OP_BGE:    info = op_info_t'{FMT_B,  MATCH_BGE};
            OP_BLTU:   info = op_info_t'{FMT_B,  MATCH_BLTU};
            OP_BGEU:   info = op_info_t'{FMT_B,  MATCH_BGEU};
            OP_LUI:    info = op_info_t'{FMT_U,  MATCH_LUI};
            OP_AUIPC:  info = op_info_t'{FMT_U,  MATCH_AUIPC};
            OP_JAL:    info = op_info_t'{FMT_J,  MATCH_JAL};
            default:   info = op_info_t'{FMT_BAD, NOP};
        endcase
        return info;
    endfunction

    // Range test is a sign-extension test: the upper bits must replicate the field's sign bit.
    function automatic logic imm_legal(input fmt_e fmt, input logic [31:0] imm);
        logic ok;
        case (fmt)
            FMT_R:        ok = 1'b1;
            FMT_I, FMT_S: ok = (imm[31:11] == {21{imm[11]}});
            FMT_SH:       ok = (imm[31:5] == 27'd0);
            FMT_B:        ok = (imm[31:12] == {20{imm[12]}}) && (imm[0] == 1'b0);
            FMT_J:        ok = (imm[31:20] == {12{imm[20]}}) && (imm[0] == 1'b0);
            FMT_U:        ok = (imm[11:0] == 12'd0);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: scatters register and immediate fields into the
// 32-bit RV32IM word for the op's format, or yields a NOP flagged as an error.
module instr_pack
    import riscv_enc_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    input  logic        imm_ok,
    output logic [31:0] instr,
    output logic        err
);

    op_info_t info_s;

    assign info_s = op_info(op);

    // Format assembly; an undefined op or an out-of-range immediate collapses to NOP.
    always_comb begin
        instr = NOP;
        err   = 1'b1;
        if ((info_s.fmt != FMT_BAD) && imm_ok) begin
            err = 1'b0;
            case (info_s.fmt)
                FMT_R:   instr = info_s.match | {7'd0, rs2, rs1, 3'd0, rd, 7'd0};
                FMT_I:   instr = info_s.match | {imm[11:0], rs1, 3'd0, rd, 7'd0};
                FMT_SH:  instr = info_s.match | {7'd0, imm[4:0], rs1, 3'd0, rd, 7'd0};
                FMT_S:   instr = info_s.match | {imm[11:5], rs2, rs1, 3'd0, imm[4:0], 7'd0};
                FMT_B:   instr = info_s.match | {imm[12], imm[10:5], rs2, rs1, 3'd0,
                                                 imm[4:1], imm[11], 7'd0};
                FMT_U:   instr = info_s.match | {imm[31:12], rd, 7'd0};
                FMT_J:   instr = info_s.match | {imm[20], imm[10:1], imm[11], imm[19:12],
                                                 rd, 7'd0};
                default: begin
                    instr = NOP;
                    err   = 1'b1;
                end
            endcase
        end else begin
            instr = NOP;
            err   = 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage streaming RV32IM encoder: S1 holds the accepted beat and its range
// check, S2 holds the packed word, its byte address and the error flag.
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int                 ADDR_W     = 16,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              base_set,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(3'd4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(2'd3));

    logic              s1_valid_r;
    logic [5:0]        s1_op_r;
    logic [4:0]        s1_rd_r;
    logic [4:0]        s1_rs1_r;
    logic [4:0]        s1_rs2_r;
    logic [31:0]       s1_imm_r;
    logic              s1_imm_ok_r;

    logic              out_valid_r;
    logic [31:0]       out_instr_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic              out_err_r;
    logic [ADDR_W-1:0] cnt_r;

    logic              adv2_s;
    logic              load2_s;
    logic [ADDR_W-1:0] base_s;
    logic [ADDR_W-1:0] slot_addr_s;
    logic [31:0]       pack_instr_s;
    logic              pack_err_s;

    assign adv2_s      = !out_valid_r || out_ready;
    assign in_ready    = !s1_valid_r || adv2_s;
    assign load2_s     = adv2_s && s1_valid_r;
    assign base_s      = base_addr & ALIGN_MASK;
    // A base load in the same cycle as an S2 load redirects that very beat.
    assign slot_addr_s = base_set ? base_s : cnt_r;

    assign out_valid = out_valid_r;
    assign out_instr = out_instr_r;
    assign out_addr  = out_addr_r;
    assign out_err   = out_err_r;

    // S1: capture the beat on transfer, drain when S2 takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_op_r     <= 6'd0;
            s1_rd_r     <= 5'd0;
            s1_rs1_r    <= 5'd0;
            s1_rs2_r    <= 5'd0;
            s1_imm_r    <= 32'd0;
            s1_imm_ok_r <= 1'b0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_op_r     <= in_op;
                s1_rd_r     <= in_rd;
                s1_rs1_r    <= in_rs1;
                s1_rs2_r    <= in_rs2;
                s1_imm_r    <= in_imm;
                s1_imm_ok_r <= imm_legal(op_info(in_op).fmt, in_imm);
            end
        end
    end

    instr_pack u_pack (
        .op     (s1_op_r),
        .rd     (s1_rd_r),
        .rs1    (s1_rs1_r),
        .rs2    (s1_rs2_r),
        .imm    (s1_imm_r),
        .imm_ok (s1_imm_ok_r),
        .instr  (pack_instr_s),
        .err    (pack_err_s)
    );

    // S2 output register and address counter; error beats do not consume an address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_instr_r <= NOP;
            out_addr_r  <= RESET_ADDR;
            out_err_r   <= 1'b0;
            cnt_r       <= RESET_ADDR;
        end else begin
            if (load2_s) begin
                out_valid_r <= 1'b1;
                out_instr_r <= pack_instr_s;
                out_err_r   <= pack_err_s;
                out_addr_r  <= slot_addr_s;
                cnt_r       <= pack_err_s ? slot_addr_s : (slot_addr_s + ADDR_STEP);
            end else begin
                if (adv2_s) begin
                    out_valid_r <= 1'b0;
                end
                if (base_set) begin
                    cnt_r <= base_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (16-bit and 4-bit address) share stimulus;
// expectations come from an ISA-table encoder and a queue of in-flight beats.
module tb_instr_encoder;
    import riscv_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, base_set, out_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic [15:0] base_addr;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_instr;
    logic [15:0] out_addr;
    logic        in_ready4, out_valid4, out_err4;
    logic [31:0] out_instr4;
    logic [3:0]  out_addr4;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(16), .RESET_ADDR(16'd0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .base_set(base_set), .base_addr(base_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    instr_encoder #(.ADDR_W(4), .RESET_ADDR(4'd4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .base_set(base_set), .base_addr(base_addr[3:0]), .out_valid(out_valid4),
        .out_ready(out_ready), .out_instr(out_instr4), .out_addr(out_addr4), .out_err(out_err4)
    );

    typedef struct {
        int          acc;
        logic [31:0] w;
        logic        e;
        bit          addressed;
        int          a16;
        int          a4;
    } beat_t;

    beat_t       q[$];
    logic [31:0] em_instr[$];
    int          em_a16[$];
    int          em_a4[$];
    logic        em_err[$];
    int          edge_cnt = 0;
    int          cnt16 = 0;
    int          cnt4 = 4;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ISA-table encoder: {format letter, opcode, funct3, funct7}, fields placed by arithmetic.
    function automatic void ref_enc(input logic [5:0] op, input logic [4:0] rd, rs1, rs2,
                                    input logic [31:0] imm, output logic [31:0] w, output logic e);
        logic [24:0] t;
        logic [7:0]  f;
        logic [31:0] opc, f3, f7, rdv, r1v, r2v;
        int          s;
        bit          ok;
        case (op)
            OP_ADD:    t = {"R", 7'h33, 3'd0, 7'h00};  OP_SUB:   t = {"R", 7'h33, 3'd0, 7'h20};
            OP_SLL:    t = {"R", 7'h33, 3'd1, 7'h00};  OP_SLT:   t = {"R", 7'h33, 3'd2, 7'h00};
            OP_SLTU:   t = {"R", 7'h33, 3'd3, 7'h00};  OP_XOR:   t = {"R", 7'h33, 3'd4, 7'h00};
            OP_SRL:    t = {"R", 7'h33, 3'd5, 7'h00};  OP_SRA:   t = {"R", 7'h33, 3'd5, 7'h20};
            OP_OR:     t = {"R", 7'h33, 3'd6, 7'h00};  OP_AND:   t = {"R", 7'h33, 3'd7, 7'h00};
            OP_MUL:    t = {"R", 7'h33, 3'd0, 7'h01};  OP_MULH:  t = {"R", 7'h33, 3'd1, 7'h01};
            OP_MULHSU: t = {"R", 7'h33, 3'd2, 7'h01};  OP_MULHU: t = {"R", 7'h33, 3'd3, 7'h01};
            OP_DIV:    t = {"R", 7'h33, 3'd4, 7'h01};  OP_DIVU:  t = {"R", 7'h33, 3'd5, 7'h01};
            OP_REM:    t = {"R", 7'h33, 3'd6, 7'h01};  OP_REMU:  t = {"R", 7'h33, 3'd7, 7'h01};
            OP_ADDI:   t = {"I", 7'h13, 3'd0, 7'h00};  OP_SLTI:  t = {"I", 7'h13, 3'd2, 7'h00};
            OP_SLTIU:  t = {"I", 7'h13, 3'd3, 7'h00};  OP_XORI:  t = {"I", 7'h13, 3'd4, 7'h00};
            OP_ORI:    t = {"I", 7'h13, 3'd6, 7'h00};  OP_ANDI:  t = {"I", 7'h13, 3'd7, 7'h00};
            OP_LB:     t = {"I", 7'h03, 3'd0, 7'h00};  OP_LH:    t = {"I", 7'h03, 3'd1, 7'h00};
            OP_LW:     t = {"I", 7'h03, 3'd2, 7'h00};  OP_LBU:   t = {"I", 7'h03, 3'd4, 7'h00};
            OP_LHU:    t = {"I", 7'h03, 3'd5, 7'h00};  OP_JALR:  t = {"I", 7'h67, 3'd0, 7'h00};
            OP_SLLI:   t = {"H", 7'h13, 3'd1, 7'h00};  OP_SRLI:  t = {"H", 7'h13, 3'd5, 7'h00};
            OP_SRAI:   t = {"H", 7'h13, 3'd5, 7'h20};
            OP_SB:     t = {"S", 7'h23, 3'd0, 7'h00};  OP_SH:    t = {"S", 7'h23, 3'd1, 7'h00};
            OP_SW:     t = {"S", 7'h23, 3'd2, 7'h00};
            OP_BEQ:    t = {"B", 7'h63, 3'd0, 7'h00};  OP_BNE:   t = {"B", 7'h63, 3'd1, 7'h00};
            OP_BLT:    t = {"B", 7'h63, 3'd4, 7'h00};  OP_BGE:   t = {"B", 7'h63, 3'd5, 7'h00};
            OP_BLTU:   t = {"B", 7'h63, 3'd6, 7'h00};  OP_BGEU:  t = {"B", 7'h63, 3'd7, 7'h00};
            OP_LUI:    t = {"U", 7'h37, 3'd0, 7'h00};  OP_AUIPC: t = {"U", 7'h17, 3'd0, 7'h00};
            OP_JAL:    t = {"J", 7'h6F, 3'd0, 7'h00};
            default:   t = {"X", 7'h00, 3'd0, 7'h00};
        endcase
        f   = t[24:17];
        opc = 32'(t[16:10]);
        f3  = 32'(t[9:7]) << 12;
        f7  = 32'(t[6:0]) << 25;
        rdv = 32'(rd) << 7;
        r1v = 32'(rs1) << 15;
        r2v = 32'(rs2) << 20;
        s   = int'(imm);
        ok  = 1'b0;
        w   = 32'h0000_0013;
        case (f)
            "R": begin ok = 1'b1; w = f7 | r2v | r1v | f3 | rdv | opc; end
            "I": begin ok = (s >= -2048) && (s <= 2047);
                       w = ((imm & 32'hFFF) << 20) | r1v | f3 | rdv | opc; end
            "H": begin ok = (s >= 0) && (s <= 31);
                       w = f7 | ((imm & 32'h1F) << 20) | r1v | f3 | rdv | opc; end
            "S": begin ok = (s >= -2048) && (s <= 2047);
                       w = (((imm >> 5) & 32'h7F) << 25) | r2v | r1v | f3 | ((imm & 32'h1F) << 7) | opc; end
            "B": begin ok = (s >= -4096) && (s <= 4094) && ((imm & 32'd1) == 32'd0);
                       w = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25) | r2v | r1v | f3
                           | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'd1) << 7) | opc; end
            "U": begin ok = ((imm & 32'hFFF) == 32'd0); w = (imm & 32'hFFFF_F000) | rdv | opc; end
            "J": begin ok = (s >= -1048576) && (s <= 1048574) && ((imm & 32'd1) == 32'd0);
                       w = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                           | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12) | rdv | opc; end
            default: ok = 1'b0;
        endcase
        e = !ok;
        if (!ok) w = 32'h0000_0013;
    endfunction

    // One clock: check outputs against the in-flight queue, then advance it across the edge.
    task automatic tick(output bit acc);
        bit    exp_rdy, exp_ov, fire_out;
        beat_t b;
        int    a16, a4;
        #1;
        exp_rdy = (q.size() < 2) || out_ready;
        exp_ov  = (q.size() > 0) && (q[0].acc < edge_cnt);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("in_ready4", 32'(in_ready4), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("out_valid4", 32'(out_valid4), 32'(exp_ov));
        if (exp_ov) begin
            check("out_instr", out_instr, q[0].w);
            check("out_instr4", out_instr4, q[0].w);
            check("out_err", 32'(out_err), 32'(q[0].e));
            check("out_addr", 32'(out_addr), 32'(q[0].a16));
            check("out_addr4", 32'(out_addr4), 32'(q[0].a4));
        end
        acc      = in_valid && exp_rdy;
        fire_out = exp_ov && out_ready;
        if (fire_out) begin
            em_instr.push_back(out_instr);
            em_a16.push_back(int'(out_addr));
            em_a4.push_back(int'(out_addr4));
            em_err.push_back(out_err);
        end
        @(posedge clk);
        edge_cnt++;
        if (fire_out) void'(q.pop_front());
        if (acc) begin
            b.acc = edge_cnt;
            b.addressed = 1'b0;
            b.a16 = 0;
            b.a4 = 0;
            ref_enc(in_op, in_rd, in_rs1, in_rs2, in_imm, b.w, b.e);
            q.push_back(b);
        end
        if (q.size() > 0 && !q[0].addressed && q[0].acc < edge_cnt) begin
            b = q[0];
            a16 = base_set ? (int'(base_addr) & 32'hFFFC) : cnt16;
            a4  = base_set ? (int'(base_addr) & 32'hC) : cnt4;
            b.a16 = a16;
            b.a4 = a4;
            b.addressed = 1'b1;
            q[0] = b;
            cnt16 = b.e ? a16 : (a16 + 4) % 65536;
            cnt4  = b.e ? a4 : (a4 + 4) % 16;
        end else if (base_set) begin
            cnt16 = int'(base_addr) & 32'hFFFC;
            cnt4  = int'(base_addr) & 32'hC;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
        bit a;
        int n;
        n = 0;
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        do begin tick(a); n++; end while (!a && n < 40);
        if (!a) begin
            vectors++; miscompares++;
            $error("FAIL send_timeout: observed no accept expected accept within 40 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit a;
        int n;
        n = 0;
        out_ready = 1'b1; in_valid = 1'b0;
        while (q.size() > 0 && n < 40) begin tick(a); n++; end
        if (q.size() > 0) begin
            vectors++; miscompares++;
            $error("FAIL drain_timeout: observed %0d beats left expected 0", q.size());
        end
    endtask

    task automatic clear_em();
        em_instr.delete(); em_a16.delete(); em_a4.delete(); em_err.delete();
    endtask

    initial begin
        bit a;
        logic [31:0] imm_r;
        rst_n = 1'b0; in_valid = 1'b0; base_set = 1'b0; out_ready = 1'b0; base_addr = 16'd0;
        in_op = 6'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'h0000_0013);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_addr4", 32'(out_addr4), 32'd4);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Back-to-back addi/add/sub with downstream always ready
        out_ready = 1'b1;
        clear_em();
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        send(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
        drain();
        check("addi_word", em_instr[0], 32'h0050_0093);
        check("add_word", em_instr[1], 32'h0020_81B3);
        check("sub_word", em_instr[2], 32'h4020_81B3);
        check("seq_addr0", 32'(em_a16[0]), 32'd0);
        check("seq_addr1", 32'(em_a16[1]), 32'd4);
        check("seq_addr2", 32'(em_a16[2]), 32'd8);

        // One of each remaining format
        clear_em();
        send(OP_SRAI, 5'd1, 5'd1, 5'd0, 32'd3);
        send(OP_SW, 5'd0, 5'd1, 5'd2, 32'd12);
        send(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd8);
        send(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd2048);
        send(OP_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        drain();
        check("srai_word", em_instr[0], 32'h4030_D093);
        check("sw_word", em_instr[1], 32'h0020_A623);
        check("beq_word", em_instr[2], 32'h0020_8463);
        check("jal_word", em_instr[3], 32'h0010_00EF);
        check("lui_word", em_instr[4], 32'h1234_52B7);

        // Illegal beats: emitted as NOP with err, address not consumed
        clear_em();
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048);
        send(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd3);
        send(6'h3F, 5'd1, 5'd2, 5'd3, 32'd0);
        send(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd1);
        drain();
        check("err_addi_flag", 32'(em_err[0]), 32'd1);
        check("err_addi_word", em_instr[0], 32'h0000_0013);
        check("err_beq_flag", 32'(em_err[1]), 32'd1);
        check("err_op_flag", 32'(em_err[2]), 32'd1);
        check("err_no_advance", 32'(em_a16[3]), 32'(em_a16[0]));

        // Backpressure: two beats fill the pipe, the third waits
        clear_em();
        out_ready = 1'b0;
        send(OP_ORI, 5'd4, 5'd5, 5'd0, 32'd7);
        send(OP_XOR, 5'd6, 5'd4, 5'd5, 32'd0);
        in_valid = 1'b1; in_op = OP_ANDI; in_rd = 5'd7; in_imm = 32'hFFFF_FFFF;
        repeat (3) tick(a);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        send(OP_ANDI, 5'd7, 5'd1, 5'd0, 32'hFFFF_FFFF);
        drain();
        check("bp_count", 32'(em_instr.size()), 32'd3);
        check("bp_addr_step", 32'(em_a16[2] - em_a16[1]), 32'd4);

        // Wrap on the 4-bit instance after a base load of 12
        clear_em();
        base_set = 1'b1; base_addr = 16'd12;
        tick(a);
        base_set = 1'b0;
        send(OP_ADDI, 5'd1, 5'd1, 5'd0, 32'd1);
        send(OP_ADDI, 5'd1, 5'd1, 5'd0, 32'd2);
        drain();
        check("wrap_a4_0", 32'(em_a4[0]), 32'd12);
        check("wrap_a4_1", 32'(em_a4[1]), 32'd0);
        check("wrap_a16_1", 32'(em_a16[1]), 32'd16);

        // base_set in the cycle a beat enters S2; low address bits are dropped
        clear_em();
        send(OP_SLLI, 5'd2, 5'd2, 5'd0, 32'd4);
        base_set = 1'b1; base_addr = 16'h0042;
        tick(a);
        base_set = 1'b0;
        send(OP_SLLI, 5'd2, 5'd2, 5'd0, 32'd5);
        drain();
        check("coinc_addr0", 32'(em_a16[0]), 32'h40);
        check("coinc_addr1", 32'(em_a16[1]), 32'h44);

        // Async reset with both stages full
        out_ready = 1'b0;
        send(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0);
        send(OP_SUB, 5'd1, 5'd2, 5'd3, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_instr", out_instr, 32'h0000_0013);
        q.delete();
        cnt16 = 0; cnt4 = 4;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        clear_em();
        send(OP_ADDI, 5'd9, 5'd0, 5'd0, 32'd9);
        drain();
        check("post_rst_addr", 32'(em_a16[0]), 32'd0);
        check("post_rst_addr4", 32'(em_a4[0]), 32'd4);

        // Randomized traffic with random backpressure and occasional base loads
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            base_set  = ($urandom_range(0, 24) == 0);
            base_addr = 16'($urandom);
            in_op     = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(45, 63)) : 6'($urandom_range(0, 44));
            in_rd     = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
            case ($urandom_range(0, 4))
                0: imm_r = 32'($urandom_range(0, 40));
                1: imm_r = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: imm_r = 32'($urandom_range(0, 4194303)) - 32'd2097152;
                3: imm_r = 32'($urandom) & 32'hFFFF_F000;
                default: imm_r = 32'($urandom);
            endcase
            in_imm = imm_r;
            tick(a);
        end
        base_set = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
